// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial adder controller and its nibble
// adder: slice width, controller state encoding and the counter-width helper.
// ---------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   // 2'd3 is unused; the controller decodes it back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Ceiling log2 for n >= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Nibble counter width; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// ---------------------------------------------------------------------------
// nibble_adder
// 4-bit ripple-carry adder built from four full-adder cells.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry into bit 0
//   s     : 4-bit sum
//   cout  : carry out of bit 3
// ---------------------------------------------------------------------------
module nibble_adder
   import nibble_serial_adder_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds or subtracts two W = 4*NIBBLES bit operands by running a single
// nibble adder over NIBBLES cycles, least-significant nibble first, with the
// carry held in a register between nibbles.
// Ports:
//   clock, reset : system clock; asynchronous active-high reset
//   start        : request, accepted in IDLE or DONE
//   sub          : 0 = a + b + cin, 1 = a - b (cin ignored)
//   cin          : carry-in for add
//   a, b         : operands, sampled with start
//   busy         : high while nibbles are being processed
//   done         : one-cycle pulse when sum/cout are updated
//   sum, cout    : registered result, held until the next done
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        sub,
   input  logic                        cin,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   output logic                        busy,
   output logic                        done,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                        cout
);

   localparam int            W    = NIBBLE_W * NIBBLES;
   localparam int            CW   = cnt_w(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   state_e              state_q, state_d;
   logic [W-1:0]        a_q, a_d, b_q, b_d;
   logic [W-1:0]        acc_q, acc_d, sum_q, sum_d;
   logic                carry_q, carry_d, cout_q, cout_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                accept, last_nib;
   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
   logic                nib_c;

   // A new request is taken from IDLE, or from DONE for back-to-back ops.
   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_nib = (cnt_q == LAST);

   assign nib_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
   assign nib_b = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];

   nibble_adder u_nibble_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_c)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = start    ? RUN  : IDLE;
         RUN:     state_d = last_nib ? DONE : RUN;
         DONE:    state_d = start    ? RUN  : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   assign sum  = sum_q;
   assign cout = cout_q;

   // ---------------- datapath ----------------
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (accept) begin
         a_d     = a;
         // Subtract as a + ~b + 1.
         b_d     = sub ? ~b : b;
         carry_d = sub | cin;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         acc_d[NIBBLE_W*cnt_q +: NIBBLE_W] = nib_s;
         carry_d = nib_c;
         if (last_nib) begin
            // acc_d already holds the final nibble.
            sum_d  = acc_d;
            cout_d = nib_c;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that reuses one 4-bit ripple-carry nibble adder over several cycles to add or subtract two wide operands, least-significant nibble first.
- Carry is kept in a register between nibbles.
- Sits between the board-level switch/LED wrapper (or any requester) and the shared nibble adder, with a start/busy/done handshake.
- Trades latency for area against a full-width combinational adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces the idle state immediately
- start  input  1  request; sampled on the rising edge, accepted only when busy=0
- sub    input  1  0 = add, 1 = subtract (a - b); sampled with start
- cin    input  1  carry-in for add; ignored when sub=1
- a      input  W  operand A; sampled with start
- b      input  W  operand B; sampled with start
- busy   output 1  high while an operation is in progress (RUN state)
- done   output 1  one-cycle pulse: result valid and newly updated
- sum    output W  result; registered; held until the next done
- cout   output 1  final carry out of the MSB nibble; registered; held with sum

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, accumulator, carry and nibble counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge: latch a_r=a.
  - b_r = sub ? ~b : b.
  - carry = sub ? 1 : cin.
  - count = 0; go to RUN.
- IDLE, start=0: stay.
- RUN, each edge: nibble adder inputs are a_r[4*count+:4], b_r[4*count+:4] and carry.
  - Write the adder's 4-bit sum into acc[4*count+:4]; carry <= adder cout.
  - If count==NIBBLES-1, go to DONE; else count <= count+1.
- On the RUN->DONE edge: sum <= full accumulator including the final nibble; cout <= final adder cout.
- DONE: done=1 for exactly this one cycle; busy=0.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- busy=1 exactly in RUN; done=1 exactly in DONE; both are decoded from registered state (no combinational path from start).
- Latency: start sampled in cycle c -> RUN in cycles c+1..c+NIBBLES -> done=1 in cycle c+NIBBLES+1. Throughput: one operation per NIBBLES+1 cycles.
- start while busy=1 is ignored; it is not queued, and in-flight operands are unaffected by changes on a, b, sub or cin.
- sum/cout do not change during RUN; they update only on entry to DONE.
- Arithmetic: W-bit modular result.
  - Add: {cout,sum} = a + b + cin.
  - Subtract: sum = a - b mod 2^W; cout = 1 means no borrow (a >= b unsigned).
- Reset asserted mid-RUN: the operation is aborted, no done pulse, outputs return to reset values.
- Reset released: first start is accepted on the first rising edge with reset low.

Decomposition:
- Shared package holds:
  - NIBBLE_W = 4
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE
  - Counter width function clog2(NIBBLES)
- One sub-module, nibble_adder: 4-bit ripple-carry adder built from four full-adder cells; inputs a[3:0], b[3:0], cin; outputs s[3:0], cout.
- The controller instantiates exactly one nibble_adder; all sequencing lives in the controller.

Test Plan:
- Reset, then NIBBLES=4, a=16'h00FF, b=16'h0001, sub=0, cin=0, start one cycle -> busy high for 4 cycles; done in cycle c+5; sum=16'h0100, cout=0.
- a=16'hFFFF, b=16'h0001, sub=0, cin=1 -> sum=16'h0001, cout=1 (carry ripples across every nibble boundary).
- Subtract a=16'h1234, b=16'h0235, sub=1, cin=1 (ignored) -> sum=16'h0FFF, cout=1. Then a=16'h0001, b=16'h0002 -> sum=16'hFFFF, cout=0.
- Hold start=1 continuously with new operands presented each DONE cycle -> operations complete every 5 cycles. Start pulses and operand changes during RUN are ignored, and sum stays at the previous result until the next done.
- Assert reset asynchronously during the 2nd RUN cycle -> busy, done, sum and cout drop to 0 immediately; no done pulse follows. A fresh start after release completes normally.
- Random regression, 1000 ops, mixed sub/cin, NIBBLES=2 and 8 -> {cout,sum} matches the reference model; done spacing is always NIBBLES+1.
